alu_operand_sequencer: RTL and testbench

- Upstream stage of the 7-segment display block.
- Captures two 6-bit two's-complement operands from slide switches using one debounced ENTER button.
- Executes one of eight ALU operations on the captured operands.
- Presents registered A, B and result (plus flags) to the display stage, which shows their signed magnitudes.

---
 rtl/alu_operand_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_alu_operand_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer
//   Captures two 6-bit two's-complement operands from the slide switches with a
//   single debounced ENTER button, runs one of eight ALU operations on them and
//   presents registered A, B, result and flags to the display stage.
//
// Ports
//   clk        system clock, all state on rising edge
//   reset      synchronous active-high reset
//   sw         operand entry switches (two's complement)
//   op_sel     operation select (0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT, 6 SHL, 7 ASR)
//   enter      raw ENTER button, asynchronous, may bounce
//   A, B       captured operands
//   result     ALU result
//   overflow   signed overflow of ADD/SUB
//   zero       result == 0
//   negative   result[5]
//   state_led  one-hot phase indicator (001 load A, 010 load B, 100 exec/show)
module alu_operand_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] sw,
    input  logic [2:0] op_sel,
    input  logic       enter,
    output logic [5:0] A,
    output logic [5:0] B,
    output logic [5:0] result,
    output logic       overflow,
    output logic       zero,
    output logic       negative,
    output logic [2:0] state_led
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        StLoadA,
        StLoadB,
        StExec,
        StShow
    } state_e;

    // ENTER conditioning
    logic            sync1_q, sync2_q;
    logic            deb_q, deb_dly_q;
    logic [CntW-1:0] cnt_q;
    logic            press;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            deb_q     <= 1'b0;
            deb_dly_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sync1_q   <= enter;
            sync2_q   <= sync1_q;
            deb_dly_q <= deb_q;
            if (sync2_q == deb_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CntLast) begin
                // Level has differed for DEBOUNCE_CYCLES consecutive cycles.
                deb_q <= sync2_q;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Both terms are flops, so press is a clean one-cycle pulse per debounced rise.
    assign press = deb_q & ~deb_dly_q;

    // ALU
    logic [5:0] a_q, b_q, res_q;
    logic       ovf_q, zero_q, neg_q;
    logic [5:0] alu_res;
    logic       alu_ovf;

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        unique case (op_sel)
            3'd0: begin
                alu_res = a_q + b_q;
                alu_ovf = (a_q[5] == b_q[5]) && (alu_res[5] != a_q[5]);
            end
            3'd1: begin
                alu_res = a_q - b_q;
                alu_ovf = (a_q[5] != b_q[5]) && (alu_res[5] != a_q[5]);
            end
            3'd2: alu_res = a_q & b_q;
            3'd3: alu_res = a_q | b_q;
            3'd4: alu_res = a_q ^ b_q;
            3'd5: alu_res = ~a_q;
            3'd6: alu_res = {a_q[4:0], 1'b0};
            3'd7: alu_res = {a_q[5], a_q[5:1]};
            default: alu_res = '0;
        endcase
    end

    // Sequencer
    state_e     state_q, state_d;
    logic [5:0] a_d, b_d, res_d;
    logic       ovf_d, zero_d, neg_d;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        neg_d   = neg_q;
        unique case (state_q)
            StLoadA: begin
                if (press) begin
                    a_d     = sw;
                    state_d = StLoadB;
                end
            end
            StLoadB: begin
                if (press) begin
                    b_d     = sw;
                    state_d = StExec;
                end
            end
            StExec, StShow: begin
                // Re-evaluated every cycle so the user can browse operations.
                res_d  = alu_res;
                ovf_d  = alu_ovf;
                zero_d = (alu_res == 6'd0);
                neg_d  = alu_res[5];
                if (state_q == StExec) begin
                    state_d = StShow;
                end else if (press) begin
                    state_d = StLoadA;
                end
            end
            default: state_d = StLoadA;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StLoadA;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b1;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
        end
    end

    always_comb begin
        state_led = 3'b100;
        unique case (state_q)
            StLoadA: state_led = 3'b001;
            StLoadB: state_led = 3'b010;
            default: state_led = 3'b100;
        endcase
    end

    assign A        = a_q;
    assign B        = b_q;
    assign result   = res_q;
    assign overflow = ovf_q;
    assign zero     = zero_q;
    assign negative = neg_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer (DEBOUNCE_CYCLES = 16).
module tb_alu_operand_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] sw;
    logic [2:0] op_sel;
    logic       enter;
    logic [5:0] A, B, result;
    logic       overflow, zero, negative;
    logic [2:0] state_led;

    int checks = 0;
    int errors = 0;
    int led_changes = 0;
    logic [2:0] prev_led = 3'b001;

    alu_operand_sequencer #(.DEBOUNCE_CYCLES(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .sw        (sw),
        .op_sel    (op_sel),
        .enter     (enter),
        .A         (A),
        .B         (B),
        .result    (result),
        .overflow  (overflow),
        .zero      (zero),
        .negative  (negative),
        .state_led (state_led)
    );

    always #5 clk = ~clk;

    // Count phase indicator changes a little after each rising edge.
    always begin
        @(posedge clk);
        #2;
        if (state_led != prev_led) led_changes++;
        prev_led = state_led;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Clean press: hold long enough to debounce, release long enough to settle.
    task automatic press(input logic [5:0] val);
        sw    = val;
        enter = 1'b1;
        tick(30);
        enter = 1'b0;
        tick(30);
    endtask

    task automatic bounce_then_hold(input logic [5:0] val);
        sw = val;
        for (int i = 0; i < 12; i++) begin
            enter = (i % 2 == 0);
            tick(5);
        end
        check_val("bounce_no_press", {29'd0, state_led}, {29'd0, prev_led});
        enter = 1'b1;
        tick(30);
        enter = 1'b0;
        tick(30);
    endtask

    int base;
    int lat;

    initial begin
        reset  = 1'b1;
        sw     = '0;
        op_sel = '0;
        enter  = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(1);
        check_val("rst_A", A, 0);
        check_val("rst_B", B, 0);
        check_val("rst_result", result, 0);
        check_val("rst_flags", {overflow, zero, negative}, 3'b010);
        check_val("rst_led", state_led, 3'b001);

        // 1: 5 + (-3) = 2
        press(6'b000101);
        check_val("t1_led_b", state_led, 3'b010);
        press(6'b111101);
        check_val("t1_A", A, 6'd5);
        check_val("t1_B", B, 6'b111101);
        check_val("t1_result", result, 6'b000010);
        check_val("t1_flags", {overflow, zero, negative}, 3'b000);
        check_val("t1_led", state_led, 3'b100);

        // 2: 25 + 10 overflows to -29; SUB gives 15
        press(6'd0);
        check_val("t2_led_a", state_led, 3'b001);
        press(6'd25);
        press(6'd10);
        check_val("t2_add", result, 6'b100011);
        check_val("t2_add_flags", {overflow, zero, negative}, 3'b101);
        op_sel = 3'd1;
        tick(1);
        check_val("t2_sub", result, 6'd15);
        check_val("t2_sub_flags", {overflow, zero, negative}, 3'b000);
        op_sel = 3'd2;
        tick(1);
        check_val("t2_and", result, 6'b001000);
        op_sel = 3'd3;
        tick(1);
        check_val("t2_or", result, 6'b011011);
        op_sel = 3'd4;
        tick(1);
        check_val("t2_xor", result, 6'b010011);
        op_sel = 3'd5;
        tick(1);
        check_val("t2_not", result, 6'b100110);
        check_val("t2_not_flags", {overflow, zero, negative}, 3'b001);

        // 3: -32 - 1 overflows to 31; ASR -> -16; SHL -> 0
        op_sel = 3'd1;
        press(6'd0);
        press(6'b100000);
        press(6'd1);
        check_val("t3_sub", result, 6'b011111);
        check_val("t3_sub_flags", {overflow, zero, negative}, 3'b100);
        op_sel = 3'd7;
        tick(1);
        check_val("t3_asr", result, 6'b110000);
        check_val("t3_asr_flags", {overflow, zero, negative}, 3'b001);
        op_sel = 3'd6;
        tick(1);
        check_val("t3_shl", result, 6'd0);
        check_val("t3_shl_flags", {overflow, zero, negative}, 3'b010);

        // 4: bouncy presses each count once
        press(6'd0);
        check_val("t4_led_a", state_led, 3'b001);
        base = led_changes;
        bounce_then_hold(6'd12);
        check_val("t4_one_press_a", led_changes - base, 1);
        check_val("t4_led_b", state_led, 3'b010);
        check_val("t4_A", A, 6'd12);
        base = led_changes;
        bounce_then_hold(6'd3);
        check_val("t4_one_press_b", led_changes - base, 1);
        check_val("t4_B", B, 6'd3);
        check_val("t4_led_show", state_led, 3'b100);

        // 5: reset in load-B abandons the sequence
        press(6'd0);
        press(6'd7);
        check_val("t5_A7", A, 6'd7);
        check_val("t5_led_b", state_led, 3'b010);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check_val("t5_A", A, 0);
        check_val("t5_B", B, 0);
        check_val("t5_result", result, 0);
        check_val("t5_zero", zero, 1);
        check_val("t5_led", state_led, 3'b001);
        press(6'd9);
        check_val("t5_A9", A, 6'd9);
        check_val("t5_B0", B, 6'd0);
        check_val("t5_led_b2", state_led, 3'b010);

        // 6: long hold gives one press; measure latency
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        base = led_changes;
        sw    = 6'b010110;
        enter = 1'b1;
        lat   = 0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            #1;
            if (A == 6'b010110) begin
                lat = n;
                break;
            end
        end
        if (!(lat >= 18 && lat <= 20))
            $display("latency observed %0d edges (0 = never)", lat);
        check_val("t6_latency_in_range", (lat >= 18 && lat <= 20), 1);
        tick(1000 - lat);
        check_val("t6_one_press", led_changes - base, 1);
        check_val("t6_led_b", state_led, 3'b010);
        check_val("t6_B0", B, 6'd0);
        enter = 1'b0;
        tick(30);
        check_val("t6_after_release", state_led, 3'b010);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
